// File: rtl/axi_bus_pkg.sv
// Shared AXI-lite bus definitions: scheduler state encoding and response codes.
package axi_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] RESP_OKAY = 3'b000;
  localparam logic [2:0] RESP_ERR  = 3'b010;

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first requester found searching upward from
// last+1 with wrap-around, returned both one-hot and as an index.
module axi_rr_picker #(
  parameter int MASTER_NUM = 2,
  parameter int IDX_W      = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      last,
  output logic [MASTER_NUM-1:0] win,
  output logic [IDX_W-1:0]      win_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable written here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 1; off <= MASTER_NUM; off++) begin
      cand = IDX_W'((int'(last) + off) % MASTER_NUM);
      if (!found && req[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        win_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_read_rr_scheduler.sv
// Round-robin owner of the shared SRAM AXI-lite read port; grant is held from AR
// to the single-beat R handshake. Optional R-wait timeout: AXI_RD_TIMEOUT_EN.
module axi_read_rr_scheduler
  import axi_bus_pkg::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 32
`ifdef AXI_RD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MASTER_NUM-1:0]          m_arvalid,
  output logic [MASTER_NUM-1:0]          m_arready,
  input  logic [MASTER_NUM*ADDR_LEN-1:0] m_raddr,
  output logic [MASTER_NUM-1:0]          m_rvalid,
  input  logic [MASTER_NUM-1:0]          m_rready,
  output logic [2:0]                     m_rresp,
  output logic [DATA_LEN-1:0]            m_rdata,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  output logic [ADDR_LEN-1:0]            s_raddr,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  input  logic [2:0]                     s_rresp,
  input  logic [DATA_LEN-1:0]            s_rdata,
  output logic [MASTER_NUM-1:0]          grant,
  output logic                           busy
);

  localparam int IDX_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  state_t                state, state_nxt;
  logic [MASTER_NUM-1:0] grant_nxt, win;
  logic [IDX_W-1:0]      gidx, gidx_nxt, last, last_nxt, win_idx;

`ifdef AXI_RD_TIMEOUT_EN
  logic [7:0] tmo_cnt, tmo_cnt_nxt;
  logic       timed_out;
  assign timed_out = (tmo_cnt == 8'(TIMEOUT_CYCLES));
`endif

  axi_rr_picker #(
    .MASTER_NUM (MASTER_NUM),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req     (m_arvalid),
    .last    (last),
    .win     (win),
    .win_idx (win_idx)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= IDX_W'(MASTER_NUM - 1);
`ifdef AXI_RD_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      gidx  <= gidx_nxt;
      last  <= last_nxt;
`ifdef AXI_RD_TIMEOUT_EN
      tmo_cnt <= tmo_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    last_nxt  = last;
    m_arready = '0;
    m_rvalid  = '0;
    m_rresp   = s_rresp;
    m_rdata   = s_rdata;
    s_arvalid = 1'b0;
    s_raddr   = m_raddr[gidx*ADDR_LEN +: ADDR_LEN];
    s_rready  = 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
    tmo_cnt_nxt = '0;
`endif
    case (state)
      IDLE: begin
        if (|m_arvalid) begin
          state_nxt = ADDR;
          grant_nxt = win;
          gidx_nxt  = win_idx;
        end
      end
      ADDR: begin
        s_arvalid       = m_arvalid[gidx];
        m_arready[gidx] = s_arready;
        // A withdrawn request abandons the slot without advancing priority.
        if (!m_arvalid[gidx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (s_arready) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
`ifdef AXI_RD_TIMEOUT_EN
        if (timed_out) begin
          m_rvalid[gidx] = 1'b1;
          m_rresp        = RESP_ERR;
          m_rdata        = '0;
          tmo_cnt_nxt    = tmo_cnt;
          if (m_rready[gidx]) begin
            state_nxt = DRAIN;
            last_nxt  = gidx;
            grant_nxt = '0;
          end
        end else begin
          tmo_cnt_nxt = s_rvalid ? tmo_cnt : tmo_cnt + 8'd1;
`endif
          m_rvalid[gidx] = s_rvalid;
          s_rready       = m_rready[gidx];
          if (s_rvalid && m_rready[gidx]) begin
            state_nxt = IDLE;
            last_nxt  = gidx;
            grant_nxt = '0;
          end
`ifdef AXI_RD_TIMEOUT_EN
        end
`endif
      end
`ifdef AXI_RD_TIMEOUT_EN
      DRAIN: begin
        // The late beat belongs to an already-failed request; swallow it.
        s_rready = 1'b1;
        if (s_rvalid) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi_read_rr_scheduler.sv
// Self-checking bench for axi_read_rr_scheduler: master agents, a slave model and
// a scoreboard of expected R beats. Timeout scenario needs AXI_RD_TIMEOUT_EN.
module tb_axi_read_rr_scheduler;
  import axi_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready, grant;
  logic [63:0] m_raddr;
  logic [2:0]  m_rresp, s_rresp;
  logic [31:0] m_rdata, s_raddr, s_rdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, busy;

  axi_read_rr_scheduler #(.MASTER_NUM(2), .ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_raddr(m_raddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_raddr(s_raddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic [2:0]  resp;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        exp_q[$];
  int          order_q[$];
  logic [31:0] ifu_q[$], lsu_q[$];
  bit          waiting[2], ar_done[2], r_done[2], abort_req[2];
  bit          pending, slave_mute, expect_err, lsu_ready_leak;
  bit          s_ar_hs, s_r_hs;
  logic [31:0] paddr, cap_addr;
  logic [1:0]  rv_seen;
  int          r_latency, lat, ar_stall, last_served;
  int          cyc, ar_cyc, r_cyc, rh_count;

  function automatic logic [31:0] ref_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h1234_5678 : (a ^ 32'hdead_beef);
  endfunction

  // Negedge observer: handshakes seen here complete at the following posedge.
  task automatic monitor();
    txn_t        t;
    logic [31:0] a;
    cyc++;
    s_ar_hs  = s_arvalid && s_arready;
    s_r_hs   = s_rvalid && s_rready;
    cap_addr = s_raddr;
    if (rst) return;
    rv_seen |= m_rvalid;
    if (grant == 2'b01 && m_arready[1]) lsu_ready_leak = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (m_arvalid[i] && m_arready[i]) begin
        a = m_raddr[i*32 +: 32];
        checks++;
        if (!(s_arvalid && s_raddr == a)) begin
          errors++;
          $display("FAIL ar_route m%0d: s_arvalid=%0b s_raddr=%h, need 1 and %h", i, s_arvalid, s_raddr, a);
        end
        t.m    = i;
        t.data = expect_err ? 32'h0 : ref_data(a);
        t.resp = expect_err ? RESP_ERR : RESP_OKAY;
        exp_q.push_back(t);
        order_q.push_back(i);
        ar_done[i] = 1'b1;
        ar_cyc     = cyc;
      end
      if (m_rvalid[i] && m_rready[i]) begin
        r_done[i] = 1'b1;
        r_cyc     = cyc;
        rh_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected m%0d: rdata=%h rresp=%b with no request outstanding", i, m_rdata, m_rresp);
        end else begin
          t = exp_q.pop_front();
          if (t.m != i || m_rdata !== t.data || m_rresp !== t.resp || m_rvalid[1-i] !== 1'b0) begin
            errors++;
            $display("FAIL r_beat: got m%0d data=%h resp=%b rvalid=%b, need m%0d data=%h resp=%b",
                     i, m_rdata, m_rresp, m_rvalid, t.m, t.data, t.resp);
          end
          last_served = i;
        end
      end
    end
  endtask

  task automatic pop_req(input int i, output bit ok, output logic [31:0] a);
    ok = 1'b0;
    a  = '0;
    if (i == 0 && ifu_q.size() > 0) begin a = ifu_q.pop_front(); ok = 1'b1; end
    if (i == 1 && lsu_q.size() > 0) begin a = lsu_q.pop_front(); ok = 1'b1; end
  endtask

  // Posedge+2 driver: slave model and the two master agents.
  task automatic drive();
    bit          ok;
    logic [31:0] a;
    if (rst) begin
      m_arvalid = '0;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
      pending   = 1'b0;
      ar_stall  = 0;
      for (int i = 0; i < 2; i++) begin
        waiting[i] = 1'b0; ar_done[i] = 1'b0; r_done[i] = 1'b0; abort_req[i] = 1'b0;
      end
      return;
    end
    if (s_r_hs) begin pending = 1'b0; s_rvalid = 1'b0; end
    if (s_ar_hs) begin pending = 1'b1; paddr = cap_addr; lat = r_latency; end
    if (pending && !s_rvalid) begin
      if (lat > 0) lat--;
      else if (!slave_mute) begin
        s_rvalid = 1'b1;
        s_rdata  = ref_data(paddr);
        s_rresp  = RESP_OKAY;
      end
    end
    if (ar_stall > 0) ar_stall--;
    s_arready = !pending && (ar_stall == 0);
    for (int i = 0; i < 2; i++) begin
      if (ar_done[i]) begin m_arvalid[i] = 1'b0; waiting[i] = 1'b1; end
      if (r_done[i]) waiting[i] = 1'b0;
      if (abort_req[i] && m_arvalid[i]) begin m_arvalid[i] = 1'b0; abort_req[i] = 1'b0; end
      ar_done[i] = 1'b0;
      r_done[i]  = 1'b0;
      if (!m_arvalid[i] && !waiting[i]) begin
        pop_req(i, ok, a);
        if (ok) begin m_raddr[i*32 +: 32] = a; m_arvalid[i] = 1'b1; end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
    drive();
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && ifu_q.size() == 0 && lsu_q.size() == 0 && m_arvalid == 2'b00 &&
             !waiting[0] && !waiting[1] && !busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_idle_timeout: not idle after %0d cycles, need idle", tag, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({grant, busy, s_arvalid, s_rready, m_arready, m_rvalid} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b busy=%b s_arvalid=%b s_rready=%b m_arready=%b m_rvalid=%b, need all 0",
               grant, busy, s_arvalid, s_rready, m_arready, m_rvalid);
    end
    rst = 1'b0;
    tick();
    order_q.delete();
    ifu_q.push_back(32'h0000_0010);
    lsu_q.push_back(32'h0000_0020);
    wait_idle(50, "reset");
    checks++;
    if (order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 1) begin
      errors++;
      $display("FAIL reset_first_priority: order size %0d first m%0d, need m0 then m1",
               order_q.size(), (order_q.size() > 0) ? order_q[0] : -1);
    end
  endtask

  task automatic test_single();
    int n = 0;
    r_latency = 2;
    rv_seen   = '0;
    ifu_q.push_back(32'h8000_0000);
    while (!m_arvalid[0] && n < 20) begin tick(); n++; end
    checks++;
    if (!(m_arvalid[0] && !s_arvalid && !busy)) begin
      errors++;
      $display("FAIL single_arb_cycle: m_arvalid0=%b s_arvalid=%b busy=%b, need 1 0 0", m_arvalid[0], s_arvalid, busy);
    end
    tick();
    checks++;
    if (!(s_arvalid && s_raddr == 32'h8000_0000 && grant == 2'b01)) begin
      errors++;
      $display("FAIL single_addr: s_arvalid=%b s_raddr=%h grant=%b, need 1 80000000 01", s_arvalid, s_raddr, grant);
    end
    wait_idle(50, "single");
    checks++;
    if (rv_seen !== 2'b01) begin
      errors++;
      $display("FAIL single_rvalid_route: rvalid seen=%b, need 01", rv_seen);
    end
  endtask

  task automatic test_round_robin();
    int first = 1 - last_served;
    order_q.delete();
    for (int k = 0; k < 4; k++) begin
      ifu_q.push_back(32'h0000_1000 + 32'(k * 4));
      lsu_q.push_back(32'h0000_2000 + 32'(k * 4));
    end
    wait_idle(300, "rr");
    checks++;
    if (order_q.size() != 8) begin
      errors++;
      $display("FAIL rr_count: %0d grants, need 8", order_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (order_q[k] != (first + k) % 2) begin
          errors++;
          $display("FAIL rr_order[%0d]: got m%0d, need m%0d", k, order_q[k], (first + k) % 2);
        end
      end
    end
  endtask

  task automatic test_ar_stall();
    int n = 0;
    order_q.delete();
    lsu_ready_leak = 1'b0;
    ar_stall = 6;
    ifu_q.push_back(32'h0000_3000);
    while (grant != 2'b01 && n < 20) begin tick(); n++; end
    lsu_q.push_back(32'h0000_4000);
    wait_idle(60, "stall");
    checks++;
    if (lsu_ready_leak || order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 1) begin
      errors++;
      $display("FAIL stall_holdoff: lsu_arready leak=%b grants=%0d, need leak 0 and m0 then m1",
               lsu_ready_leak, order_q.size());
    end
  endtask

  task automatic test_drop();
    int n = 0;
    int exp_winner = 1 - last_served;
    order_q.delete();
    ar_stall = 40;
    ifu_q.push_back(32'h0000_5000);
    while (grant != 2'b01 && n < 20) begin tick(); n++; end
    abort_req[0] = 1'b1;
    tick();
    tick();
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: grant=%b busy=%b, need 00 0", grant, busy);
    end
    ar_stall = 0;
    ifu_q.push_back(32'h0000_6000);
    lsu_q.push_back(32'h0000_7000);
    wait_idle(60, "drop");
    checks++;
    if (order_q.size() != 2 || order_q[0] != exp_winner) begin
      errors++;
      $display("FAIL drop_next_winner: got m%0d, need m%0d", (order_q.size() > 0) ? order_q[0] : -1, exp_winner);
    end
  endtask

  task automatic test_rst_mid();
    int n = 0;
    r_latency = 10;
    ifu_q.push_back(32'h0000_8000);
    while (!s_rready && n < 20) begin tick(); n++; end
    rst = 1'b1;
    tick();
    checks++;
    if ({grant, busy, s_arvalid, s_rready, m_arready, m_rvalid} !== 9'd0) begin
      errors++;
      $display("FAIL rst_mid: grant=%b busy=%b s_arvalid=%b s_rready=%b m_arready=%b m_rvalid=%b, need all 0",
               grant, busy, s_arvalid, s_rready, m_arready, m_rvalid);
    end
    exp_q.delete();
    last_served = 1;
    rst = 1'b0;
    r_latency = 1;
    tick();
    order_q.delete();
    ifu_q.push_back(32'h0000_9000);
    lsu_q.push_back(32'h0000_a000);
    wait_idle(60, "rst_mid");
    checks++;
    if (order_q.size() != 2 || order_q[0] != 0) begin
      errors++;
      $display("FAIL rst_mid_priority: first m%0d, need m0", (order_q.size() > 0) ? order_q[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    order_q.delete();
    for (int k = 0; k < 3; k++) ifu_q.push_back(32'h0000_b000 + 32'(k * 4));
    wait_idle(80, "b2b");
    checks++;
    if (order_q.size() != 3 || order_q[0] != 0 || order_q[1] != 0 || order_q[2] != 0) begin
      errors++;
      $display("FAIL b2b_order: %0d grants, need three to m0", order_q.size());
    end
  endtask

`ifdef AXI_RD_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    int before = rh_count;
    order_q.delete();
    slave_mute = 1'b1;
    expect_err = 1'b1;
    ifu_q.push_back(32'h0000_c000);
    while (rh_count == before && n < 400) begin tick(); n++; end
    expect_err = 1'b0;
    checks++;
    if (rh_count == before || r_cyc - ar_cyc != 256) begin
      errors++;
      $display("FAIL timeout_delay: ERR beat after %0d cycles, need 256", r_cyc - ar_cyc);
    end
    checks++;
    if (!(busy && grant == 2'b00 && s_rready && m_arready == 2'b00)) begin
      errors++;
      $display("FAIL drain_state: busy=%b grant=%b s_rready=%b m_arready=%b, need 1 00 1 00",
               busy, grant, s_rready, m_arready);
    end
    lsu_q.push_back(32'h0000_d000);
    repeat (3) tick();
    checks++;
    if (!(busy && m_arready == 2'b00 && m_arvalid[1])) begin
      errors++;
      $display("FAIL drain_holdoff: busy=%b m_arready=%b, need 1 00", busy, m_arready);
    end
    slave_mute = 1'b0;
    wait_idle(60, "timeout");
    checks++;
    if (order_q.size() != 2 || order_q[1] != 1) begin
      errors++;
      $display("FAIL timeout_next: %0d grants, need m0 then m1", order_q.size());
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    m_arvalid = '0; m_raddr = '0; m_rready = 2'b11;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rresp = '0; s_rdata = '0;
    pending = 1'b0; slave_mute = 1'b0; expect_err = 1'b0; lsu_ready_leak = 1'b0;
    r_latency = 2; lat = 0; ar_stall = 0; last_served = 1;
    cyc = 0; ar_cyc = 0; r_cyc = 0; rh_count = 0; rv_seen = '0;
    paddr = '0; cap_addr = '0; s_ar_hs = 1'b0; s_r_hs = 1'b0;
    for (int i = 0; i < 2; i++) begin
      waiting[i] = 1'b0; ar_done[i] = 1'b0; r_done[i] = 1'b0; abort_req[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_ar_stall();
    test_drop();
    test_rst_mid();
    test_back_to_back();
`ifdef AXI_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
